// File: rtl/id_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl_pkg
// Shared constants for the instruction-decode stage controller and its
// instruction FIFO: instruction width, PC width, default FIFO depth and the
// default stall performance counter width.
// -----------------------------------------------------------------------------
package id_stage_ctrl_pkg;

    localparam int DEF_INSN_LEN = 32;
    localparam int DEF_ADDR_LEN = 32;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/id_inst_fifo.sv
// -----------------------------------------------------------------------------
// id_inst_fifo
// Parameterised synchronous FIFO holding fetched instruction entries in front
// of the decoder. No bypass: a pushed entry becomes visible at head_o only
// after the write edge.
//
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   synchronous reset, active-high (pointers and count to 0)
//   flush_i  in   synchronous flush, same effect as reset
//   push_i   in   write wdata_i at the tail (ignored when full)
//   pop_i    in   retire the head entry (ignored when empty)
//   wdata_i  in   entry to write
//   head_o   out  entry at the read pointer (meaningful only when not empty)
//   count_o  out  number of stored entries
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
// -----------------------------------------------------------------------------
module id_inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; every consumer of head_o gates it with count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// -----------------------------------------------------------------------------
// id_stage_ctrl
// Sequencing controller for the instruction-decode stage. Buffers fetched
// instructions in id_inst_fifo, presents the FIFO head to the decoder, drives
// the ID pipeline register load/clear, and tracks valid, invalid-slot and PC
// of the instruction held in the ID register. Counts stalled-valid cycles.
//
// Ports:
//   clk_i, reset_i     clock; synchronous active-high reset
//   if_valid_i/if_inst_i/if_pc_i/if_inv_i   fetch offer
//   if_ready_o         offer accepted when if_valid_i & if_ready_o & ~kill_i
//   kill_i             flush FIFO and ID register (branch recovery)
//   stall_dp_i         dispatch stall: ID register holds
//   dec_inst_o         FIFO head to the decoder, 0 when empty
//   id_load_o          ID register load enable
//   id_clear_o         ID register clear (reset_i | kill_i)
//   id_valid_o/id_inv_o/id_pc_o   state of the ID-register instruction
//   occupancy_o        FIFO entry count
//   stall_cnt_o        saturating count of stalled-valid cycles
//
// Fetch handshake: an instruction transfers on a rising edge where
// if_valid_i & if_ready_o & ~kill_i. if_ready_o depends only on registered
// FIFO count and reset_i, so it never combinationally follows stall or kill.
// -----------------------------------------------------------------------------
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int INSN_LEN = DEF_INSN_LEN,
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     if_valid_i,
    input  logic [INSN_LEN-1:0]      if_inst_i,
    input  logic [ADDR_LEN-1:0]      if_pc_i,
    input  logic                     if_inv_i,
    output logic                     if_ready_o,
    input  logic                     kill_i,
    input  logic                     stall_dp_i,
    output logic [INSN_LEN-1:0]      dec_inst_o,
    output logic                     id_load_o,
    output logic                     id_clear_o,
    output logic                     id_valid_o,
    output logic                     id_inv_o,
    output logic [ADDR_LEN-1:0]      id_pc_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam int EW = 1 + ADDR_LEN + INSN_LEN;

    logic [EW-1:0]        w_wdata;
    logic [EW-1:0]        w_head;
    logic                 w_head_inv;
    logic [ADDR_LEN-1:0]  w_head_pc;
    logic [INSN_LEN-1:0]  w_head_inst;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_nonempty;
    logic                 w_push;
    logic                 w_pop;

    logic                 r_id_valid;
    logic                 r_id_inv;
    logic [ADDR_LEN-1:0]  r_id_pc;
    logic [CNT_W-1:0]     r_stall_cnt;

    assign w_wdata = {if_inv_i, if_pc_i, if_inst_i};
    assign {w_head_inv, w_head_pc, w_head_inst} = w_head;
    assign w_nonempty = ~w_empty;

    // At full, ready stays low even if a pop happens this cycle.
    assign if_ready_o = ~w_full & ~reset_i;
    assign w_push     = if_valid_i & if_ready_o & ~kill_i;
    assign id_load_o  = ~stall_dp_i & ~kill_i & ~reset_i;
    assign id_clear_o = reset_i | kill_i;
    assign w_pop      = id_load_o & w_nonempty;
    assign dec_inst_o = w_nonempty ? w_head_inst : '0;

    id_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (kill_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wdata),
        .head_o  (w_head),
        .count_o (occupancy_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_id_valid  <= 1'b0;
            r_id_inv    <= 1'b0;
            r_id_pc     <= '0;
            r_stall_cnt <= '0;
        end else if (kill_i) begin
            // PC is left as-is; it is meaningless while valid is low.
            r_id_valid <= 1'b0;
            r_id_inv   <= 1'b0;
        end else begin
            if (stall_dp_i && r_id_valid && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (id_load_o) begin
                // Loading from an empty FIFO inserts a bubble.
                r_id_valid <= w_nonempty;
                r_id_inv   <= w_head_inv & w_nonempty;
                if (w_nonempty) r_id_pc <= w_head_pc;
            end
        end
    end

    assign id_valid_o  = r_id_valid;
    assign id_inv_o    = r_id_inv;
    assign id_pc_o     = r_id_pc;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_stage_ctrl
// Self-checking bench for id_stage_ctrl (DEPTH = 2, CNT_W = 4). A queue-based
// reference tracks accepted fetch entries; a table of directed vectors carries
// hand-derived expectations, followed by stall-counter, mid-stream reset and
// random sequences.
// -----------------------------------------------------------------------------
module tb_id_stage_ctrl;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_inst_i = '0;
    logic [31:0] if_pc_i = '0;
    logic        if_inv_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        stall_dp_i = 1'b0;
    logic        if_ready_o;
    logic [31:0] dec_inst_o;
    logic        id_load_o;
    logic        id_clear_o;
    logic        id_valid_o;
    logic        id_inv_o;
    logic [31:0] id_pc_o;
    logic [1:0]  occupancy_o;
    logic [3:0]  stall_cnt_o;

    always #5 clk_i = ~clk_i;

    id_stage_ctrl #(
        .DEPTH    (DEPTH),
        .INSN_LEN (32),
        .ADDR_LEN (32),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .if_valid_i  (if_valid_i),
        .if_inst_i   (if_inst_i),
        .if_pc_i     (if_pc_i),
        .if_inv_i    (if_inv_i),
        .if_ready_o  (if_ready_o),
        .kill_i      (kill_i),
        .stall_dp_i  (stall_dp_i),
        .dec_inst_o  (dec_inst_o),
        .id_load_o   (id_load_o),
        .id_clear_o  (id_clear_o),
        .id_valid_o  (id_valid_o),
        .id_inv_o    (id_inv_o),
        .id_pc_o     (id_pc_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    // ---------------- scoreboard / reference ----------------
    logic [64:0] exp_q[$];       // {inv, pc, inst} of accepted, not yet loaded entries
    logic        m_valid = 1'b0;
    logic        m_inv = 1'b0;
    logic [31:0] m_pc = '0;
    logic [3:0]  m_cnt = '0;
    logic        last_rdy = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic rst, input logic vld, input logic [31:0] inst,
                         input logic [31:0] pc, input logic inv, input logic kill,
                         input logic stall);
        logic        e_rdy;
        logic        e_push;
        logic        e_load;
        logic [31:0] e_dec;
        logic [64:0] ent;
        reset_i    = rst;
        if_valid_i = vld;
        if_inst_i  = inst;
        if_pc_i    = pc;
        if_inv_i   = inv;
        kill_i     = kill;
        stall_dp_i = stall;
        #1;
        e_rdy  = (exp_q.size() < DEPTH) && !rst;
        e_push = vld && e_rdy && !kill;
        e_load = !stall && !kill && !rst;
        e_dec  = (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0;
        last_rdy = if_ready_o;
        chk("if_ready", {63'b0, if_ready_o}, {63'b0, e_rdy});
        chk("id_load", {63'b0, id_load_o}, {63'b0, e_load});
        chk("id_clear", {63'b0, id_clear_o}, {63'b0, rst | kill});
        chk("dec_inst", {32'b0, dec_inst_o}, {32'b0, e_dec});
        if (rst) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_inv   = 1'b0;
            m_pc    = '0;
            m_cnt   = '0;
        end else if (kill) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_inv   = 1'b0;
        end else begin
            if (stall && m_valid && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (e_load) begin
                if (exp_q.size() != 0) begin
                    ent     = exp_q.pop_front();
                    m_valid = 1'b1;
                    m_inv   = ent[64];
                    m_pc    = ent[63:32];
                end else begin
                    m_valid = 1'b0;
                    m_inv   = 1'b0;
                end
            end
            if (e_push) exp_q.push_back({inv, pc, inst});
        end
        @(posedge clk_i);
        #1;
        chk("occupancy", {62'b0, occupancy_o}, 64'(exp_q.size()));
        chk("id_valid", {63'b0, id_valid_o}, {63'b0, m_valid});
        chk("id_inv", {63'b0, id_inv_o}, {63'b0, m_inv});
        chk("id_pc", {32'b0, id_pc_o}, {32'b0, m_pc});
        chk("stall_cnt", {60'b0, stall_cnt_o}, {60'b0, m_cnt});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, vld;
        logic [31:0] inst, pc;
        logic        inv, kill, stall;
        logic        e_rdy;
        logic [1:0]  e_occ;
        logic        e_val;
        logic [31:0] e_pc;
        logic        e_inv;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_vec(input logic rst, input logic vld, input logic [31:0] inst,
                           input logic [31:0] pc, input logic inv, input logic kill,
                           input logic stall, input logic e_rdy, input logic [1:0] e_occ,
                           input logic e_val, input logic [31:0] e_pc, input logic e_inv,
                           input logic [3:0] e_cnt);
        vec_t v;
        v = '{rst, vld, inst, pc, inv, kill, stall, e_rdy, e_occ, e_val, e_pc, e_inv, e_cnt};
        vec_q.push_back(v);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t v;
        //       rst   vld   inst          pc          inv   kill  stall  rdy  occ   val   pc          inv   cnt
        add_vec(1'b1, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00000013, 32'h100,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,      1'b0, 4'd0);
        add_vec(1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h100,    1'b0, 4'd0);
        add_vec(1'b1, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,      1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00100093, 32'h100,    1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,      1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00200113, 32'h104,    1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,      1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00300193, 32'h108,    1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,      1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00300193, 32'h108,    1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h100,    1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00300193, 32'h108,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h104,    1'b0, 4'd0);
        add_vec(1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h108,    1'b0, 4'd0);
        add_vec(1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h108,    1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00400213, 32'h10C,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h108,    1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00500293, 32'h110,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h10C,    1'b0, 4'd0);
        add_vec(1'b0, 1'b1, 32'h00600313, 32'h114,    1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 32'h10C,    1'b0, 4'd1);
        add_vec(1'b0, 1'b1, 32'h00700393, 32'h118,    1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h10C,    1'b0, 4'd1);
        add_vec(1'b0, 1'b1, 32'h00800413, 32'h11C,    1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h10C,    1'b0, 4'd1);
        add_vec(1'b0, 1'b1, 32'h00900493, 32'h200,    1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h10C,    1'b0, 4'd1);
        add_vec(1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h200,    1'b1, 4'd1);
        add_vec(1'b0, 1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h200,    1'b0, 4'd1);

        // Power-on reset: outputs are not compared until the first reset edge.
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vec_q.size(); i++) begin
            v = vec_q[i];
            cycle(v.rst, v.vld, v.inst, v.pc, v.inv, v.kill, v.stall);
            chk($sformatf("tbl%0d_rdy", i), {63'b0, last_rdy}, {63'b0, v.e_rdy});
            chk($sformatf("tbl%0d_occ", i), {62'b0, occupancy_o}, {62'b0, v.e_occ});
            chk($sformatf("tbl%0d_val", i), {63'b0, id_valid_o}, {63'b0, v.e_val});
            chk($sformatf("tbl%0d_pc", i), {32'b0, id_pc_o}, {32'b0, v.e_pc});
            chk($sformatf("tbl%0d_inv", i), {63'b0, id_inv_o}, {63'b0, v.e_inv});
            chk($sformatf("tbl%0d_cnt", i), {60'b0, stall_cnt_o}, {60'b0, v.e_cnt});
        end

        // ---------------- stall counter and saturation ----------------
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000A013, 32'h300, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_pre_valid", {63'b0, id_valid_o}, 64'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_cnt_5", {60'b0, stall_cnt_o}, 64'd5);
        chk("stall_pc_hold", {32'b0, id_pc_o}, 64'h300);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_cnt_sat", {60'b0, stall_cnt_o}, 64'hF);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_cnt_sat_hold", {60'b0, stall_cnt_o}, 64'hF);

        // ---------------- mid-stream reset ----------------
        cycle(1'b0, 1'b1, 32'h0000B013, 32'h400, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000C013, 32'h404, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000D013, 32'h408, 1'b0, 1'b0, 1'b0);
        chk("rst_ready_low", {63'b0, last_rdy}, 64'd0);
        chk("rst_occ", {62'b0, occupancy_o}, 64'd0);
        chk("rst_valid", {63'b0, id_valid_o}, 64'd0);
        chk("rst_pc", {32'b0, id_pc_o}, 64'd0);
        chk("rst_cnt", {60'b0, stall_cnt_o}, 64'd0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_after_dec", {32'b0, dec_inst_o}, 64'd0);

        // ---------------- random traffic ----------------
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 2) != 0,
                  32'($urandom),
                  32'($urandom) & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
